// File: rtl/reg32_en_comp.sv
// Parallel-load register with synchronous load-enable and a true/complement output pair.
// Build option: define REG32_COMP_OUT_EN to drive Q_comp = ~Q; otherwise Q_comp is tied to zero.

module reg32_en_comp_cell (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic d_i,
  output logic q_o,
  output logic q_comp_o
);

  logic q_q;
  logic q_d;

  // Load mux: enable selects new data, otherwise recirculate the stored bit
  always_comb begin
    q_d = q_q;
    if (enable) begin
      q_d = d_i;
    end else begin
      q_d = q_q;
    end
  end

  // Storage element with synchronous clear taking priority over the load mux
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

`ifdef REG32_COMP_OUT_EN
  assign q_comp_o = ~q_q;
`else
  assign q_comp_o = 1'b0;
`endif

endmodule

module reg32_en_comp #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_comp
);

  // One cell per bit; clk, reset and enable are shared so all bits load or hold together
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    reg32_en_comp_cell u_cell (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .d_i      (D[i]),
      .q_o      (Q[i]),
      .q_comp_o (Q_comp[i])
    );
  end

endmodule

// File: tb/tb_reg32_en_comp.sv
// Scoreboard bench for reg32_en_comp; expected words are queued when driven and checked after the edge.
// Run once with and once without REG32_COMP_OUT_EN defined.

module tb_reg32_en_comp;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             enable;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Q_comp;

  int checks;
  int errors;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] model_q;
  logic             model_valid;

  reg32_en_comp #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .D      (D),
    .Q      (Q),
    .Q_comp (Q_comp)
  );

  initial begin
    clk = 1'b1;
    forever #9 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  // Drive one cycle of stimulus while clk=1, check hold at the falling edge, then score after the rising edge.
  task automatic step(input string tag, input logic r, input logic e, input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] exp;
    reset  = r;
    enable = e;
    D      = d;
    nxt = r ? {WIDTH{1'b0}} : (e ? d : model_q);
    exp_q.push_back(nxt);
    @(negedge clk);
    #1;
    if (model_valid) begin
      check_val({tag, "_midcycle"}, Q, model_q);
    end
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      exp = exp_q.pop_front();
      check_val({tag, "_q"}, Q, exp);
`ifdef REG32_COMP_OUT_EN
      check_val({tag, "_qcomp"}, Q_comp, ~exp);
`else
      check_val({tag, "_qcomp_tied"}, Q_comp, {WIDTH{1'b0}});
`endif
    end
    model_q     = nxt;
    model_valid = 1'b1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    model_q     = '0;
    model_valid = 1'b0;
    reset       = 1'b1;
    enable      = 1'b1;
    D           = 32'hFFFFFFFF;

    step("reset",        1'b1, 1'b1, 32'hFFFFFFFF);
    step("hold_zero",    1'b0, 1'b0, 32'h5A5A5A5A);
    step("load_ones",    1'b0, 1'b1, 32'hFFFFFFFF);
    step("load_pattern", 1'b0, 1'b1, 32'h80000801);
    step("hold",         1'b0, 1'b0, 32'hAAAAAAAA);
    step("half_cycle",   1'b0, 1'b1, 32'h401FF805);
    step("rst_priority", 1'b1, 1'b1, 32'h12345678);
    step("after_reset",  1'b0, 1'b1, 32'h12345678);
    step("rst_no_en",    1'b1, 1'b0, 32'hDEADBEEF);
    step("load_zero",    1'b0, 1'b1, 32'h00000000);
    step("load_alt",     1'b0, 1'b1, 32'h55555555);

    for (int i = 0; i < 40; i++) begin
      step("rand", ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
           $urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, WIDTH'($urandom()));
    end

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
